// File: rtl/big_fv_iter_scheduler.sv
// Iteration scheduler for the ping/pong Big FV bank array: launches one phase per
// (update, replay) pair and waits for every bank. Optional watchdog: BIG_FV_SCHED_TIMEOUT_EN.
module big_fv_iter_scheduler #(
  parameter int NUM_BANKS  = 4,
  parameter int MAX_REPLAY = 4,
  parameter int MAX_UPDATE = 4,
  parameter int MAX_FV     = 64,
  parameter int TIMEOUT    = 1024,
  localparam int RW = $clog2(MAX_REPLAY),
  localparam int UW = $clog2(MAX_UPDATE),
  localparam int FW = $clog2(MAX_FV)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [RW-1:0]        cfg_last_replay,
  input  logic [UW-1:0]        cfg_last_update,
  input  logic [FW-1:0]        cfg_fv_num,
  input  logic [NUM_BANKS-1:0] bank_done,
  output logic                 phase_start,
  output logic [RW-1:0]        cur_replay_iter,
  output logic [UW-1:0]        cur_update_iter,
  output logic [FW-1:0]        fv_num,
  output logic                 ping_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SWAP,
    S_FINISH
  } state_t;

  state_t               state, state_nxt;
  logic [NUM_BANKS-1:0] done_mask, done_mask_nxt, done_merged;
  logic [RW-1:0]        last_replay, last_replay_nxt, replay_nxt;
  logic [UW-1:0]        last_update, last_update_nxt, update_nxt;
  logic [FW-1:0]        fv_num_nxt;
  logic                 ping_nxt;

`ifdef BIG_FV_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_cnt;
  logic           wd_expired;
  logic           err_nxt;

  // Counter restarts in LAUNCH so it reads zero on the first WAIT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == S_LAUNCH) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expired = (wd_cnt == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= err_nxt;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign err            = 1'b0;
`endif

  assign done_merged = done_mask | bank_done;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt       = state;
    done_mask_nxt   = done_mask;
    last_replay_nxt = last_replay;
    last_update_nxt = last_update;
    fv_num_nxt      = fv_num;
    replay_nxt      = cur_replay_iter;
    update_nxt      = cur_update_iter;
    ping_nxt        = ping_sel;
`ifdef BIG_FV_SCHED_TIMEOUT_EN
    err_nxt         = err;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          last_replay_nxt = cfg_last_replay;
          last_update_nxt = cfg_last_update;
          fv_num_nxt      = cfg_fv_num;
          replay_nxt      = '0;
          update_nxt      = '0;
          ping_nxt        = 1'b0;
`ifdef BIG_FV_SCHED_TIMEOUT_EN
          err_nxt         = 1'b0;
`endif
          state_nxt       = S_LAUNCH;
        end
      end

      // Completions arriving while the strobe is out belong to no phase and are dropped.
      S_LAUNCH: begin
        done_mask_nxt = '0;
        state_nxt     = S_WAIT;
      end

      S_WAIT: begin
        done_mask_nxt = done_merged;
        if (&done_merged) begin
          state_nxt = S_SWAP;
        end
`ifdef BIG_FV_SCHED_TIMEOUT_EN
        else if (wd_expired) begin
          err_nxt    = 1'b1;
          replay_nxt = '0;
          update_nxt = '0;
          state_nxt  = S_FINISH;
        end
`endif
      end

      // Replay is the inner loop; update advances only when replay wraps.
      S_SWAP: begin
        ping_nxt = ~ping_sel;
        if (cur_replay_iter != last_replay) begin
          replay_nxt = cur_replay_iter + 1'b1;
          state_nxt  = S_LAUNCH;
        end else begin
          replay_nxt = '0;
          if (cur_update_iter != last_update) begin
            update_nxt = cur_update_iter + 1'b1;
            state_nxt  = S_LAUNCH;
          end else begin
            update_nxt = '0;
            state_nxt  = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so they appear in the same cycle as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      done_mask       <= '0;
      last_replay     <= '0;
      last_update     <= '0;
      fv_num          <= '0;
      cur_replay_iter <= '0;
      cur_update_iter <= '0;
      ping_sel        <= 1'b0;
      phase_start     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state           <= state_nxt;
      done_mask       <= done_mask_nxt;
      last_replay     <= last_replay_nxt;
      last_update     <= last_update_nxt;
      fv_num          <= fv_num_nxt;
      cur_replay_iter <= replay_nxt;
      cur_update_iter <= update_nxt;
      ping_sel        <= ping_nxt;
      phase_start     <= (state_nxt == S_LAUNCH);
      busy            <= (state_nxt != S_IDLE);
      done            <= (state_nxt == S_FINISH);
    end
  end

endmodule

// File: tb/tb_big_fv_iter_scheduler.sv
// Self-checking bench for big_fv_iter_scheduler: table-driven full schedules plus
// hand-written reset, staggered-completion and watchdog sequences.
module tb_big_fv_iter_scheduler;

  localparam int NUM_BANKS  = 4;
  localparam int MAX_REPLAY = 4;
  localparam int MAX_UPDATE = 4;
  localparam int MAX_FV     = 64;
  localparam int TIMEOUT    = 16;
  localparam int RW         = $clog2(MAX_REPLAY);
  localparam int UW         = $clog2(MAX_UPDATE);
  localparam int FW         = $clog2(MAX_FV);
  localparam int BUDGET     = 2000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [RW-1:0]        cfg_last_replay;
  logic [UW-1:0]        cfg_last_update;
  logic [FW-1:0]        cfg_fv_num;
  logic [NUM_BANKS-1:0] bank_done;
  logic                 phase_start;
  logic [RW-1:0]        cur_replay_iter;
  logic [UW-1:0]        cur_update_iter;
  logic [FW-1:0]        fv_num;
  logic                 ping_sel;
  logic                 busy;
  logic                 done;
  logic                 err;

  big_fv_iter_scheduler #(
    .NUM_BANKS (NUM_BANKS),
    .MAX_REPLAY(MAX_REPLAY),
    .MAX_UPDATE(MAX_UPDATE),
    .MAX_FV    (MAX_FV),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_last_replay(cfg_last_replay),
    .cfg_last_update(cfg_last_update),
    .cfg_fv_num     (cfg_fv_num),
    .bank_done      (bank_done),
    .phase_start    (phase_start),
    .cur_replay_iter(cur_replay_iter),
    .cur_update_iter(cur_update_iter),
    .fv_num         (fv_num),
    .ping_sel       (ping_sel),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // One schedule: cfg, bank response delay after phase_start, optional start injected
  // while busy (cycle index, 0 = none), expected phase count, done cycle, final ping_sel.
  typedef struct {
    logic [RW-1:0] last_replay;
    logic [UW-1:0] last_update;
    logic [FW-1:0] fv;
    int            delay;
    int            busy_start_cyc;
    int            exp_phases;
    int            exp_done_cyc;
    logic          exp_ping;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int phases;
    int pulse_at;
    int exp_r;
    int exp_u;
    bit seen_done;
    cfg_last_replay = v.last_replay;
    cfg_last_update = v.last_update;
    cfg_fv_num      = v.fv;
    start           = 1'b1;
    tick();
    start           = 1'b0;
    cfg_last_replay = ~v.last_replay;
    cfg_last_update = ~v.last_update;
    cfg_fv_num      = ~v.fv;
    cyc       = 1;
    phases    = 0;
    pulse_at  = -1;
    exp_r     = 0;
    exp_u     = 0;
    seen_done = 1'b0;
    while (!seen_done && cyc < BUDGET) begin
      bank_done = '0;
      start     = 1'b0;
      if (phase_start) begin
        check($sformatf("v%0d replay idx ph%0d", idx, phases), 32'(cur_replay_iter), exp_r);
        check($sformatf("v%0d update idx ph%0d", idx, phases), 32'(cur_update_iter), exp_u);
        check($sformatf("v%0d ping_sel ph%0d", idx, phases), 32'(ping_sel), phases % 2);
        check($sformatf("v%0d fv_num ph%0d", idx, phases), 32'(fv_num), 32'(v.fv));
        phases++;
        pulse_at = cyc + v.delay;
        if (exp_r == int'(v.last_replay)) begin
          exp_r = 0;
          exp_u++;
        end else begin
          exp_r++;
        end
      end
      if (cyc == pulse_at) bank_done = '1;
      if (cyc == v.busy_start_cyc) begin
        start           = 1'b1;
        cfg_last_replay = 2'd3;
        cfg_last_update = 2'd3;
        cfg_fv_num      = 6'd50;
      end
      if (done) begin
        seen_done = 1'b1;
        check($sformatf("v%0d done cycle", idx), cyc, v.exp_done_cyc);
        check($sformatf("v%0d phase count", idx), phases, v.exp_phases);
        check($sformatf("v%0d final ping_sel", idx), 32'(ping_sel), 32'(v.exp_ping));
        check($sformatf("v%0d busy at done", idx), 32'(busy), 1);
        check($sformatf("v%0d counters at done", idx),
              32'({cur_update_iter, cur_replay_iter}), 0);
        check($sformatf("v%0d err at done", idx), 32'(err), 0);
        check($sformatf("v%0d fv_num at done", idx), 32'(fv_num), 32'(v.fv));
      end else begin
        tick();
        cyc++;
      end
    end
    if (!seen_done) check($sformatf("v%0d done within budget", idx), 0, 1);
    tick();
    start     = 1'b0;
    bank_done = '0;
    check($sformatf("v%0d busy after done", idx), 32'(busy), 0);
    check($sformatf("v%0d done one cycle", idx), 32'(done), 0);
  endtask

  logic [NUM_BANKS-1:0] stag[9];

  initial begin
    // Phases per row: (last_replay+1)*(last_update+1); done cycle = phases*(delay+2)+1.
    vecs[0] = '{2'd1, 2'd0, 6'd5,  5, 0, 2,  15, 1'b0};
    vecs[1] = '{2'd0, 2'd0, 6'd1,  1, 0, 1,  4,  1'b1};
    vecs[2] = '{2'd3, 2'd3, 6'd63, 1, 0, 16, 49, 1'b0};
    vecs[3] = '{2'd2, 2'd1, 6'd17, 3, 0, 6,  31, 1'b0};
    vecs[4] = '{2'd0, 2'd3, 6'd0,  2, 0, 4,  17, 1'b0};
    vecs[5] = '{2'd1, 2'd1, 6'd10, 2, 3, 4,  17, 1'b0};
    vecs[6] = '{2'd0, 2'd1, 6'd7,  1, 7, 2,  7,  1'b0};

    // LAUNCH-cycle pulse from bank 0, then banks 2,2,1,3,0 in WAIT; last distinct at cycle 8.
    stag[0] = 4'b0001;
    stag[1] = 4'b0100;
    stag[2] = 4'b0000;
    stag[3] = 4'b0100;
    stag[4] = 4'b0010;
    stag[5] = 4'b0000;
    stag[6] = 4'b1000;
    stag[7] = 4'b0001;
    stag[8] = 4'b0000;

    reset           = 1'b1;
    start           = 1'b0;
    cfg_last_replay = '0;
    cfg_last_update = '0;
    cfg_fv_num      = '0;
    bank_done       = '0;
    #2 reset = 1'b0;
    #1;
    check("reset busy", 32'(busy), 0);
    check("reset phase_start", 32'(phase_start), 0);
    check("reset done", 32'(done), 0);
    check("reset err", 32'(err), 0);
    check("reset ping_sel", 32'(ping_sel), 0);
    check("reset counters", 32'({cur_update_iter, cur_replay_iter}), 0);
    check("reset fv_num", 32'(fv_num), 0);
    tick();
    reset = 1'b1;
    tick();
    check("idle busy", 32'(busy), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Staggered completions on a single-phase schedule.
    cfg_last_replay = 2'd0;
    cfg_last_update = 2'd0;
    cfg_fv_num      = 6'd3;
    start           = 1'b1;
    tick();
    start = 1'b0;
    check("stag phase_start", 32'(phase_start), 1);
    for (int c = 1; c <= 9; c++) begin
      bank_done = stag[c-1];
      check($sformatf("stag no done c%0d", c), 32'(done), 0);
      tick();
    end
    bank_done = '0;
    check("stag done at c10", 32'(done), 1);
    tick();
    check("stag idle after", 32'(busy), 0);

    // Reset during the WAIT of the second phase.
    cfg_last_replay = 2'd1;
    cfg_last_update = 2'd0;
    cfg_fv_num      = 6'd9;
    start           = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      bank_done = (c == 3) ? 4'b1111 : 4'b0000;
      tick();
    end
    bank_done = '0;
    check("pre-reset ping_sel", 32'(ping_sel), 1);
    check("pre-reset replay", 32'(cur_replay_iter), 1);
    reset = 1'b0;
    tick();
    check("midrun reset busy", 32'(busy), 0);
    check("midrun reset ping_sel", 32'(ping_sel), 0);
    check("midrun reset counters", 32'({cur_update_iter, cur_replay_iter}), 0);
    check("midrun reset phase_start", 32'(phase_start), 0);
    check("midrun reset fv_num", 32'(fv_num), 0);
    #3 reset = 1'b1;
    tick();
    run_vec(vecs[0], 10);

`ifdef BIG_FV_SCHED_TIMEOUT_EN
    // Bank 0 never reports: watchdog fires after TIMEOUT WAIT cycles (cycles 2..17).
    cfg_last_replay = 2'd1;
    cfg_last_update = 2'd0;
    cfg_fv_num      = 6'd4;
    start           = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      bank_done = (c >= 2) ? 4'b1110 : 4'b0000;
      check($sformatf("wd no done c%0d", c), 32'(done), 0);
      tick();
    end
    bank_done = '0;
    check("wd done", 32'(done), 1);
    check("wd err", 32'(err), 1);
    check("wd busy", 32'(busy), 1);
    check("wd ping_sel held", 32'(ping_sel), 0);
    check("wd counters", 32'({cur_update_iter, cur_replay_iter}), 0);
    tick();
    check("wd idle", 32'(busy), 0);
    check("wd err held", 32'(err), 1);
    cfg_last_replay = 2'd0;
    cfg_last_update = 2'd0;
    start           = 1'b1;
    tick();
    start = 1'b0;
    check("wd err cleared on start", 32'(err), 0);
    for (int c = 1; c <= 3; c++) begin
      bank_done = (c == 2) ? 4'b1111 : 4'b0000;
      tick();
    end
    bank_done = '0;
    check("wd recovery done", 32'(done), 1);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

endmodule
